// File: rtl/mux_8to1.sv
// mux_8to1: eight-way WIDTH-bit multiplexer.
// The combinational output o follows the selected input with zero latency.
// The registered stage (o_q, sel_q, valid_q) captures o and the select on
// enabled clock edges. A synchronous reset clears the registered stage only.
module mux_8to1 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [WIDTH-1:0] i4,
   input  logic [WIDTH-1:0] i5,
   input  logic [WIDTH-1:0] i6,
   input  logic [WIDTH-1:0] i7,
   input  logic             s0,
   input  logic             s1,
   input  logic             s2,
   input  logic             en,
   output logic [WIDTH-1:0] o,
   output logic [WIDTH-1:0] o_q,
   output logic [2:0]       sel_q,
   output logic             valid_q
);

   // Select word; s2 is the most significant bit.
   logic [2:0] sel;
   assign sel = {s2, s1, s0};

   // Combinational select. An unknown select bit falls through to the
   // all-X default, so X on the select propagates in simulation.
   always_comb begin
      o = {WIDTH{1'bx}};
      case (sel)
         3'd0:    o = i0;
         3'd1:    o = i1;
         3'd2:    o = i2;
         3'd3:    o = i3;
         3'd4:    o = i4;
         3'd5:    o = i5;
         3'd6:    o = i6;
         3'd7:    o = i7;
         default: o = {WIDTH{1'bx}};
      endcase
   end

   // Registered stage: reset clears it and has priority over the load enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_q     <= '0;
         sel_q   <= 3'b000;
         valid_q <= 1'b0;
      end else if (en) begin
         o_q     <= o;
         sel_q   <= sel;
         valid_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mux_8to1.sv
// tb_mux_8to1: randomized self-checking bench for mux_8to1 (WIDTH=8).
// A behavioural model predicts o and the registered outputs every cycle;
// a few literal expectations pin the model to known values.
module tb_mux_8to1;

   localparam int W = 8;

   logic         clk;
   logic         clk_run;
   logic         rst;
   logic         en;
   logic [W-1:0] d [8];
   logic [2:0]   sv;
   logic [W-1:0] o;
   logic [W-1:0] o_q;
   logic [2:0]   sel_q;
   logic         valid_q;

   int checks;
   int failures;
   logic cmp_en;

   // Model state for the registered outputs
   logic [W-1:0] m_oq;
   logic [2:0]   m_selq;
   logic         m_valid;
   logic         m_known;

   mux_8to1 #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .i0(d[0]), .i1(d[1]), .i2(d[2]), .i3(d[3]),
      .i4(d[4]), .i5(d[5]), .i6(d[6]), .i7(d[7]),
      .s0(sv[0]), .s1(sv[1]), .s2(sv[2]),
      .en(en),
      .o(o), .o_q(o_q), .sel_q(sel_q), .valid_q(valid_q)
   );

   initial begin
      clk = 1'b0;
      wait (clk_run);
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: registers take the selected input on enabled edges, cleared by reset
   always @(posedge clk) begin
      if (rst) begin
         m_oq    <= '0;
         m_selq  <= 3'd0;
         m_valid <= 1'b0;
         m_known <= 1'b1;
      end else if (en) begin
         m_oq    <= d[sv];
         m_selq  <= sv;
         m_valid <= 1'b1;
      end
   end

   // Compare process on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         check("o_model", {24'd0, o}, {24'd0, d[sv]});
         if (m_known) begin
            check("o_q_model", {24'd0, o_q}, {24'd0, m_oq});
            check("sel_q_model", {29'd0, sel_q}, {29'd0, m_selq});
            check("valid_q_model", {31'd0, valid_q}, {31'd0, m_valid});
         end
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      cmp_en   = 1'b0;
      clk_run  = 1'b0;
      m_known  = 1'b0;
      rst      = 1'b0;
      en       = 1'b0;
      sv       = 3'd0;

      // Pattern 1,0,1,0,... swept through every select with no clock running
      for (int k = 0; k < 8; k++) d[k] = (k % 2 == 0) ? 8'd1 : 8'd0;
      for (int s = 0; s < 8; s++) begin
         sv = s[2:0];
         #1;
         check("noclk_sweep_o", {24'd0, o}, (s % 2 == 0) ? 32'd1 : 32'd0);
      end

      // Reset with enable high
      cmp_en  = 1'b1;
      clk_run = 1'b1;
      rst = 1'b1;
      en  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_o_q", {24'd0, o_q}, 32'd0);
      check("rst_sel_q", {29'd0, sel_q}, 32'd0);
      check("rst_valid_q", {31'd0, valid_q}, 32'd0);

      // i_k = 8'h10+k, sel=5
      rst = 1'b0;
      for (int k = 0; k < 8; k++) d[k] = 8'h10 + k[7:0];
      sv = 3'd5;
      #1;
      check("sel5_o", {24'd0, o}, 32'h15);
      @(posedge clk); #1;
      check("sel5_o_q", {24'd0, o_q}, 32'h15);
      check("sel5_sel_q", {29'd0, sel_q}, 32'd5);
      check("sel5_valid_q", {31'd0, valid_q}, 32'd1);

      // Reset wins over enable; o keeps showing the selected input
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_pri_o_q", {24'd0, o_q}, 32'd0);
      check("rst_pri_sel_q", {29'd0, sel_q}, 32'd0);
      check("rst_pri_valid_q", {31'd0, valid_q}, 32'd0);
      check("rst_pri_o", {24'd0, o}, 32'h15);

      // Idle edge after reset keeps valid low, then reload with sel=2
      rst = 1'b0;
      en  = 1'b0;
      @(posedge clk); #1;
      check("post_rst_valid_q", {31'd0, valid_q}, 32'd0);
      en = 1'b1;
      sv = 3'd2;
      @(posedge clk); #1;
      check("reload_o_q", {24'd0, o_q}, 32'h12);

      // Enable low while sel walks 3,4,6: registers hold, o follows
      en = 1'b0;
      sv = 3'd3;
      @(posedge clk); #1;
      sv = 3'd4;
      @(posedge clk); #1;
      sv = 3'd6;
      #1;
      check("hold_o_follows", {24'd0, o}, 32'h16);
      @(posedge clk); #1;
      check("hold_o_q", {24'd0, o_q}, 32'h12);
      check("hold_sel_q", {29'd0, sel_q}, 32'd2);

      // sel=3: unselected inputs toggle without effect, i3 toggle propagates
      en = 1'b1;
      sv = 3'd3;
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) if (k != 3) d[k] = ~d[k];
      #1;
      check("unsel_toggle_o", {24'd0, o}, 32'h13);
      @(posedge clk); #1;
      check("unsel_toggle_o_q", {24'd0, o_q}, 32'h13);
      d[3] = ~d[3];
      #1;
      check("sel_toggle_o", {24'd0, o}, 32'hEC);
      check("sel_toggle_o_q_before", {24'd0, o_q}, 32'h13);
      @(posedge clk); #1;
      check("sel_toggle_o_q", {24'd0, o_q}, 32'hEC);

      // Random data and select over 1000 enabled cycles
      en = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
         sv = 3'($urandom_range(0, 7));
         @(posedge clk); #1;
      end

      // Random enable with occasional mid-stream reset
      for (int n = 0; n < 300; n++) begin
         for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
         sv  = 3'($urandom_range(0, 7));
         en  = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 19) == 0);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      cmp_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
